// File: rtl/shift_scheduler.sv
// shift_scheduler
//   Shares one iterative shift unit between two requesters. An idle unit
//   grants one requester round-robin, latches its operand, then shifts it
//   over one or more cycles and holds the result on the response port
//   until the consumer takes it.
//
// Ports
//   clock      : single clock, all state changes on posedge
//   reset      : synchronous, active-low reset
//   reqValid   : bit i set when requester i presents an op
//   reqReady   : bit i set when requester i's op is accepted this cycle
//   reqRight   : bit i set selects logical right shift, clear selects left
//   reqValue   : operand of requester i at [i*W +: W]
//   reqAmount  : unsigned shift amount of requester i at [i*W +: W]
//   rspValid   : result available
//   rspReady   : consumer takes the result
//   rspId      : requester that issued the op being returned
//   rspResult  : shifted value, truncated to W bits
//   busy       : set whenever the unit is not idle
module shift_scheduler #(
  parameter int MemoryElementWidth = 12,
  parameter int ShiftPerCycle      = 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [1:0]                      reqValid,
  output logic [1:0]                      reqReady,
  input  logic [1:0]                      reqRight,
  input  logic [2*MemoryElementWidth-1:0] reqValue,
  input  logic [2*MemoryElementWidth-1:0] reqAmount,
  output logic                            rspValid,
  input  logic                            rspReady,
  output logic                            rspId,
  output logic [MemoryElementWidth-1:0]   rspResult,
  output logic                            busy
);

  localparam int W = MemoryElementWidth;
  localparam logic [W-1:0] STEP_MAX = W'(ShiftPerCycle);
  localparam logic [W-1:0] WIDTH_VAL = W'(W);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    RESP
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] value_q, value_d;
  logic [W-1:0] remaining_q, remaining_d;
  logic         right_q, right_d;
  logic         id_q, id_d;
  logic         last_grant_q, last_grant_d;

  logic         grant;
  logic         any_valid;
  logic [W-1:0] sel_value;
  logic [W-1:0] sel_amount;
  logic         sel_right;
  logic [W-1:0] step;
  logic [W-1:0] shifted;

  // Round-robin pick: a lone requester always wins, a tie goes to the
  // requester that was not granted last time.
  always_comb begin
    any_valid = |reqValid;
    grant     = 1'b0;
    if (reqValid == 2'b11) begin
      grant = ~last_grant_q;
    end else if (reqValid[1]) begin
      grant = 1'b1;
    end
    sel_value  = grant ? reqValue[2*W-1:W]  : reqValue[W-1:0];
    sel_amount = grant ? reqAmount[2*W-1:W] : reqAmount[W-1:0];
    sel_right  = grant ? reqRight[1]        : reqRight[0];
  end

  // Accept handshake is combinational so the op is taken on the same edge;
  // reset low forces it off regardless of the registered state.
  always_comb begin
    reqReady = 2'b00;
    if (reset && (state_q == IDLE) && any_valid) begin
      reqReady = grant ? 2'b10 : 2'b01;
    end
  end

  // One shift step moves at most ShiftPerCycle bits, fewer on the last step
  // so the total equals the requested amount. Both directions zero fill.
  always_comb begin
    step    = (remaining_q > STEP_MAX) ? STEP_MAX : remaining_q;
    shifted = right_q ? (value_q >> step) : (value_q << step);
  end

  // Next-state logic. Amounts of zero or at least W need no shifting and
  // go straight to the response state with their final value.
  always_comb begin
    state_d      = state_q;
    value_d      = value_q;
    remaining_d  = remaining_q;
    right_d      = right_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          id_d         = grant;
          last_grant_d = grant;
          right_d      = sel_right;
          if (sel_amount == '0) begin
            value_d     = sel_value;
            remaining_d = '0;
            state_d     = RESP;
          end else if (sel_amount >= WIDTH_VAL) begin
            value_d     = '0;
            remaining_d = '0;
            state_d     = RESP;
          end else begin
            value_d     = sel_value;
            remaining_d = sel_amount;
            state_d     = SHIFT;
          end
        end
      end
      SHIFT: begin
        value_d     = shifted;
        remaining_d = remaining_q - step;
        if (remaining_q == step) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rspReady) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset abandons any op in flight and restores the
  // tie-break so requester 0 wins the first tie.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      value_q      <= '0;
      remaining_q  <= '0;
      right_q      <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      value_q      <= value_d;
      remaining_q  <= remaining_d;
      right_q      <= right_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rspValid  = (state_q == RESP);
  assign rspResult = value_q;
  assign rspId     = id_q;
  assign busy      = (state_q != IDLE);

endmodule
